// File: rtl/pulse_to_level.sv
// -----------------------------------------------------------------------------
// pulse_to_level
//
// Stretches a request pulse into a level that stays high for HOLD_CYCLES
// cycles. After each hold the level is forced low for GAP_CYCLES cycles
// before a new request can be accepted.
//   - RETRIGGER=1: a pulse seen while holding restarts the hold.
//   - RETRIGGER=0: a pulse seen while holding is dropped.
//   - A pulse seen during the gap is always dropped.
// Dropped pulses raise `missed` for one cycle and bump the saturating
// `miss_count`.
//
// Handshake: none. `pulse` is a plain synchronous request, sampled on every
// rising edge of clk. There is no back-pressure, and requests the block
// cannot take are reported through missed/miss_count.
//
// Parameters
//   HOLD_CYCLES : cycles level stays high per accepted pulse (1..2^CNT_W)
//   GAP_CYCLES  : forced-low cycles after a hold (0..2^CNT_W)
//   RETRIGGER   : 1 = restart hold on pulse, 0 = drop pulse during hold
//   CNT_W       : width of the shared hold/gap down-counter
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   pulse      : request input
//   level      : registered stretched level (high iff state is HOLD)
//   busy       : registered, high iff state is not IDLE
//   missed     : registered one-cycle flag for a dropped pulse
//   miss_count : registered saturating count of dropped pulses
//   dbg_state  : current FSM state encoding (00 IDLE, 01 HOLD, 10 GAP)
// -----------------------------------------------------------------------------
module pulse_to_level #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter bit          RETRIGGER   = 1'b1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse,
  output logic       level,
  output logic       busy,
  output logic       missed,
  output logic [7:0] miss_count,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  // The counter always holds "cycles remaining minus one", so exit happens
  // when it reads zero and it never has to go negative.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  =
    CNT_W'((GAP_CYCLES != 0) ? (GAP_CYCLES - 1) : 0);
  localparam bit               HAS_GAP   = (GAP_CYCLES != 0);

  // Registered state
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_busy;
  logic             r_missed;
  logic [7:0]       r_miss_count;

  // Next-state and next-output values
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_drop;
  logic             w_level_nxt;
  logic             w_busy_nxt;
  logic             w_missed_nxt;
  logic [7:0]       w_miss_count_nxt;

  // ---------------------------------------------------------------------------
  // State register. The output flops live here too, so every output is
  // driven straight from a flop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_level      <= 1'b0;
      r_busy       <= 1'b0;
      r_missed     <= 1'b0;
      r_miss_count <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_level      <= w_level_nxt;
      r_busy       <= w_busy_nxt;
      r_missed     <= w_missed_nxt;
      r_miss_count <= w_miss_count_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_drop      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (pulse) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = HOLD_LOAD;
        end
      end

      ST_HOLD: begin
        if (pulse && RETRIGGER) begin
          // A retrigger wins even on the last hold cycle.
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = HOLD_LOAD;
        end else begin
          w_drop = pulse;
          if (r_cnt == '0) begin
            if (HAS_GAP) begin
              w_state_nxt = ST_GAP;
              w_cnt_nxt   = GAP_LOAD;
            end else begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end

      ST_GAP: begin
        // Every request during the gap is refused, including on its last cycle.
        w_drop = pulse;
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      default: begin
        // An illegal encoding returns to IDLE on the next edge.
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. The values are derived from the next state, so the
  // registered outputs line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_level_nxt      = (w_state_nxt == ST_HOLD);
    w_busy_nxt       = (w_state_nxt != ST_IDLE);
    w_missed_nxt     = w_drop;
    w_miss_count_nxt = r_miss_count;
    if (w_drop && (r_miss_count != 8'hFF)) begin
      w_miss_count_nxt = r_miss_count + 8'd1;
    end
  end

  assign level      = r_level;
  assign busy       = r_busy;
  assign missed     = r_missed;
  assign miss_count = r_miss_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_pulse_to_level.sv
module tb_pulse_to_level;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_H = 2'b01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic p_rt = 1'b0;
  logic p_nr = 1'b0;
  logic p_g0 = 1'b0;

  logic       lv_rt, bs_rt, ms_rt;
  logic [7:0] mc_rt;
  logic [1:0] st_rt;
  logic       lv_nr, bs_nr, ms_nr;
  logic [7:0] mc_nr;
  logic [1:0] st_nr;
  logic       lv_g0, bs_g0, ms_g0;
  logic [7:0] mc_g0;
  logic [1:0] st_g0;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pulse_to_level #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1'b1), .CNT_W(8)) u_rt (
    .clk(clk), .rst(rst), .pulse(p_rt), .level(lv_rt), .busy(bs_rt),
    .missed(ms_rt), .miss_count(mc_rt), .dbg_state(st_rt));

  pulse_to_level #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1'b0), .CNT_W(8)) u_nr (
    .clk(clk), .rst(rst), .pulse(p_nr), .level(lv_nr), .busy(bs_nr),
    .missed(ms_nr), .miss_count(mc_nr), .dbg_state(st_nr));

  pulse_to_level #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .RETRIGGER(1'b1), .CNT_W(8)) u_g0 (
    .clk(clk), .rst(rst), .pulse(p_g0), .level(lv_g0), .busy(bs_g0),
    .missed(ms_g0), .miss_count(mc_g0), .dbg_state(st_g0));

  // Move 1 time unit past the next rising edge. Inputs changed here belong to
  // the new cycle, and outputs read here are that cycle's values.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves every instance idle. The next loop iteration is cycle 0.
  task automatic do_reset();
    p_rt = 1'b0; p_nr = 1'b0; p_g0 = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [12:0] act;
    rst = 1'b1;
    p_rt = 1'b0; p_nr = 1'b0; p_g0 = 1'b0;
    step();
    step();
    act = {st_rt, lv_rt, bs_rt, ms_rt, mc_rt};
    vectors++;
    if (act !== 13'd0) begin errors++; $display("FAIL reset_rt act=%h exp=0", act); end
    act = {st_nr, lv_nr, bs_nr, ms_nr, mc_nr};
    vectors++;
    if (act !== 13'd0) begin errors++; $display("FAIL reset_nr act=%h exp=0", act); end
    act = {st_g0, lv_g0, bs_g0, ms_g0, mc_g0};
    vectors++;
    if (act !== 13'd0) begin errors++; $display("FAIL reset_g0 act=%h exp=0", act); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [10:0] act, exp;
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      exp = {(c >= 11 && c <= 14), (c >= 11 && c <= 16), 1'b0, 8'd0};
      act = {lv_rt, bs_rt, ms_rt, mc_rt};
      vectors++;
      if (act !== exp) begin errors++; $display("FAIL single c=%0d act=%h exp=%h", c, act, exp); end
      p_rt = (c == 10);
      step();
    end
    p_rt = 1'b0;
  endtask

  // The second pulse lands at cycle 12 (mid-hold) and then at cycle 14
  // (the counter==0 cycle). Both extend the hold to second+4.
  task automatic test_retrigger();
    logic [10:0] act, exp;
    int sp;
    for (int k = 0; k < 2; k++) begin
      sp = 12 + 2 * k;
      do_reset();
      for (int c = 0; c <= sp + 8; c++) begin
        exp = {(c >= 11 && c <= sp + 4), (c >= 11 && c <= sp + 6), 1'b0, 8'd0};
        act = {lv_rt, bs_rt, ms_rt, mc_rt};
        vectors++;
        if (act !== exp) begin errors++; $display("FAIL retrigger sp=%0d c=%0d act=%h exp=%h", sp, c, act, exp); end
        p_rt = (c == 10) || (c == sp);
        step();
      end
      p_rt = 1'b0;
    end
  endtask

  // The pulse is held high in cycles 10..19, so level stays high in 11..23.
  task automatic test_hold_stream();
    logic [10:0] act, exp;
    do_reset();
    for (int c = 0; c <= 27; c++) begin
      exp = {(c >= 11 && c <= 23), (c >= 11 && c <= 25), 1'b0, 8'd0};
      act = {lv_rt, bs_rt, ms_rt, mc_rt};
      vectors++;
      if (act !== exp) begin errors++; $display("FAIL hold_stream c=%0d act=%h exp=%h", c, act, exp); end
      p_rt = (c >= 10 && c <= 19);
      step();
    end
    p_rt = 1'b0;
  endtask

  task automatic test_no_retrigger();
    logic [10:0] act, exp;
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      exp = {(c >= 11 && c <= 14), (c >= 11 && c <= 16), (c == 13), ((c >= 13) ? 8'd1 : 8'd0)};
      act = {lv_nr, bs_nr, ms_nr, mc_nr};
      vectors++;
      if (act !== exp) begin errors++; $display("FAIL no_retrigger c=%0d act=%h exp=%h", c, act, exp); end
      p_nr = (c == 10) || (c == 12);
      step();
    end
    p_nr = 1'b0;
  endtask

  // The pulse in cycle 15 arrives during the gap and is dropped. The pulse in
  // cycle 17 is accepted from IDLE.
  task automatic test_gap_drop();
    logic [10:0] act, exp;
    do_reset();
    for (int c = 0; c <= 25; c++) begin
      exp = {((c >= 11 && c <= 14) || (c >= 18 && c <= 21)),
             ((c >= 11 && c <= 16) || (c >= 18 && c <= 23)),
             (c == 16), ((c >= 16) ? 8'd1 : 8'd0)};
      act = {lv_nr, bs_nr, ms_nr, mc_nr};
      vectors++;
      if (act !== exp) begin errors++; $display("FAIL gap_drop c=%0d act=%h exp=%h", c, act, exp); end
      p_nr = (c == 10) || (c == 15) || (c == 17);
      step();
    end
    p_nr = 1'b0;
  endtask

  // Reset is raised part-way through cycle 12 of a hold, while missed is set,
  // and released at the start of cycle 14.
  task automatic test_reset_mid_hold();
    logic [12:0] act, exp;
    do_reset();
    for (int c = 0; c <= 27; c++) begin
      if (c == 12) begin
        exp = {ST_H, 1'b1, 1'b1, 1'b1, 8'd1};
        act = {st_nr, lv_nr, bs_nr, ms_nr, mc_nr};
        vectors++;
        if (act !== exp) begin errors++; $display("FAIL pre_reset c=%0d act=%h exp=%h", c, act, exp); end
        rst = 1'b1;
        #1;
      end
      if (c == 14) rst = 1'b0;
      exp = {(c == 11 || (c >= 21 && c <= 24)) ? ST_H : 2'b00,
             (c == 11 || (c >= 21 && c <= 24)),
             (c == 11 || (c >= 21 && c <= 26)), 1'b0, 8'd0};
      if (c >= 25 && c <= 26) exp[12:11] = 2'b10;
      act = {st_nr, lv_nr, bs_nr, ms_nr, mc_nr};
      vectors++;
      if (act !== exp) begin errors++; $display("FAIL reset_mid_hold c=%0d act=%h exp=%h", c, act, exp); end
      p_nr = (c == 10) || (c == 11) || (c == 20);
      step();
    end
    p_nr = 1'b0;
  endtask

  // The pulse is held high continuously with RETRIGGER=0. The pattern repeats
  // every 7 cycles: 4 hold, 2 gap, 1 idle. Every hold and gap cycle is a drop.
  task automatic test_saturate();
    logic [10:0] act, exp;
    int exp_mc;
    logic e_ms;
    do_reset();
    exp_mc = 0;
    for (int c = 0; c < 360; c++) begin
      e_ms = (c >= 2) && (((c - 2) % 7) < 6);
      if (e_ms && exp_mc < 255) exp_mc++;
      exp = {((c >= 1) && (((c - 1) % 7) < 4)), ((c >= 1) && (((c - 1) % 7) < 6)),
             e_ms, 8'(exp_mc)};
      act = {lv_nr, bs_nr, ms_nr, mc_nr};
      vectors++;
      if (act !== exp) begin errors++; $display("FAIL saturate c=%0d act=%h exp=%h", c, act, exp); end
      p_nr = 1'b1;
      step();
    end
    p_nr = 1'b0;
    vectors++;
    if (mc_nr !== 8'd255) begin errors++; $display("FAIL saturate_final act=%0d exp=255", mc_nr); end
  endtask

  // HOLD=1 and GAP=0. Pulses in cycles 10 and 12 give separate holds with an
  // IDLE cycle between them. Pulses in cycles 10 and 11 give a retrigger on the
  // counter==0 cycle.
  task automatic test_gap0();
    logic [12:0] act, exp;
    int sp;
    for (int k = 0; k < 2; k++) begin
      sp = 12 - k;
      do_reset();
      for (int c = 0; c <= 16; c++) begin
        exp = {(c == 11 || c == sp + 1) ? ST_H : ST_I, (c == 11 || c == sp + 1),
               (c == 11 || c == sp + 1), 1'b0, 8'd0};
        act = {st_g0, lv_g0, bs_g0, ms_g0, mc_g0};
        vectors++;
        if (act !== exp) begin errors++; $display("FAIL gap0 sp=%0d c=%0d act=%h exp=%h", sp, c, act, exp); end
        p_g0 = (c == 10) || (c == sp);
        step();
      end
      p_g0 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_retrigger();
    test_hold_stream();
    test_no_retrigger();
    test_gap_drop();
    test_reset_mid_hold();
    test_saturate();
    test_gap0();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pulse_to_level.md
PULSE_TO_LEVEL -- requirements
Module: pulse_to_level

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, is the number of cycles level is held high per accepted pulse; legal range is 1..2^CNT_W.
REQ-002 Parameter GAP_CYCLES, default 2, is the number of forced-low cycles after a hold; legal range is 0..2^CNT_W.
REQ-003 Parameter RETRIGGER, default 1: 1 means a pulse during hold restarts the hold count, 0 means it is dropped.
REQ-004 Parameter CNT_W, default 8, is the width of the internal hold/gap down-counter.
REQ-005 Port clk, input, 1 bit, is the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit, is an asynchronous, active-high reset.
REQ-007 Port pulse, input, 1 bit, is a single-cycle (or multi-cycle) request, synchronous to clk.
REQ-008 Port level, output, 1 bit, is the registered stretched level.
REQ-009 Port busy, output, 1 bit, is high whenever the FSM is not IDLE.
REQ-010 Port missed, output, 1 bit, is a registered one-cycle flag marking a dropped pulse.
REQ-011 Port miss_count, output, 8 bits, is the saturating count of dropped pulses.

Function
REQ-012 The FSM SHALL be Moore with states IDLE, HOLD and GAP, and all outputs SHALL be registered.
REQ-013 The output level SHALL be 1 iff state is HOLD, and busy SHALL be 1 iff state is not IDLE.
REQ-014 Timing convention: "cycle N" is the period in which an input is high before the edge that samples it.
REQ-015 In IDLE, pulse=1 in cycle N SHALL move the FSM to HOLD and load the counter with HOLD_CYCLES-1, so level is high in cycles N+1..N+HOLD_CYCLES.
REQ-016 In IDLE with pulse=0, the FSM SHALL remain in IDLE.
REQ-017 In HOLD, the counter SHALL decrement each cycle.
REQ-018 On leaving HOLD at counter==0 with no accepted pulse, the FSM SHALL go to GAP with counter=GAP_CYCLES-1 if GAP_CYCLES>0, else to IDLE.
REQ-019 In HOLD with RETRIGGER=1, pulse=1 (including on the counter==0 cycle) SHALL reload the counter to HOLD_CYCLES-1 and keep the FSM in HOLD.
REQ-020 In HOLD with RETRIGGER=0, pulse=1 SHALL be dropped.
REQ-021 In GAP, level SHALL be 0 and the counter SHALL decrement each cycle; at counter==0 the FSM SHALL go to IDLE.
REQ-022 Any pulse=1 in GAP, including the last GAP cycle, SHALL be dropped.
REQ-023 A dropped pulse in cycle N SHALL set missed=1 in cycle N+1 only, and SHALL increment miss_count in cycle N+1.
REQ-024 miss_count SHALL saturate at 255 and SHALL NOT wrap.
REQ-025 A pulse held high continuously with RETRIGGER=1 SHALL keep level high for its whole duration plus HOLD_CYCLES cycles.
REQ-026 A pulse held high continuously with RETRIGGER=0 SHALL produce periodic holds of HOLD_CYCLES, separated by GAP_CYCLES plus 1 IDLE cycle, with every intervening high cycle counted as missed.
REQ-027 An unreachable state encoding SHALL return the FSM to IDLE on the next edge, with level=0.
REQ-028 The counter arithmetic SHALL be unsigned CNT_W bits and SHALL never underflow, because exit occurs at 0.

Reset
REQ-029 While rst=1, state SHALL be IDLE, the counter 0, and level, busy, missed and miss_count all 0, applied asynchronously.
REQ-030 Reset asserted mid-HOLD or mid-GAP SHALL abort immediately, with level=0 in the same cycle and no residual hold after release.
REQ-031 The first pulse sampled after rst deasserts SHALL be handled per REQ-015.

Verification (HOLD_CYCLES=4, GAP_CYCLES=2 unless stated)
REQ-032 Single pulse in cycle 10 -> level=1 in cycles 11-14, busy=1 in cycles 11-16, busy=0 in cycle 17, missed never set.
REQ-033 RETRIGGER=1, pulses in cycles 10 and 12 -> level=1 in cycles 11-16 continuously, miss_count=0.
REQ-034 RETRIGGER=0, pulses in cycles 10 and 12 -> level=1 in cycles 11-14, missed=1 in cycle 13 only, miss_count=1.
REQ-035 Pulse in cycle 15 (GAP) -> dropped, with missed=1 in cycle 16; pulse in cycle 17 -> level=1 in cycles 18-21.
REQ-036 rst asserted in cycle 12 mid-HOLD -> level, busy, missed and miss_count all 0 at once; a pulse in cycle 20 after release gives level=1 in cycles 21-24.
REQ-037 RETRIGGER=0, 300 dropped pulses -> miss_count reaches 255 and stays there, and missed still pulses once per dropped pulse.
REQ-038 GAP_CYCLES=0 and HOLD_CYCLES=1, pulse in cycles 10 and 12 -> level=1 in cycles 11 and 13, with an IDLE cycle at 12.
